// File: rtl/ece423_led_pulse_pio.sv
// ece423_led_pulse_pio: Avalon-MM output PIO for board LEDs.
// A data register with set/clear aliases, plus per-bit one-shot pulses timed
// by a shared prescaler. Pulse expiry latches a done bit that can raise irq.
module ece423_led_pulse_pio #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  // A 1-bit prescaler is kept for TICK_DIV=1 so the compare is always legal;
  // it then sits at 0 and ticks every cycle.
  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_LEN    = 3'd1;
  localparam logic [2:0] A_ACTIVE = 3'd2;
  localparam logic [2:0] A_MASK   = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLR    = 3'd5;
  localparam logic [2:0] A_TRIG   = 3'd6;
  localparam logic [2:0] A_DONE   = 3'd7;

  logic [WIDTH-1:0] data_q,      data_d;
  logic [LEN_W-1:0] pulse_len_q, pulse_len_d;
  logic [WIDTH-1:0] irq_mask_q,  irq_mask_d;
  logic [WIDTH-1:0] active_q,    active_d;
  logic [WIDTH-1:0] done_q,      done_d;
  logic [PW-1:0]    presc_q,     presc_d;
  logic [LEN_W-1:0] cnt_q [WIDTH];
  logic [LEN_W-1:0] cnt_d [WIDTH];
  logic [31:0]      readdata_q,  readdata_d;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             tick;
  logic [WIDTH-1:0] trig;
  logic [WIDTH-1:0] done_clr;
  logic [WIDTH-1:0] done_set;

  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign tick     = (presc_q == PRESC_LAST);
  // A zero pulse length makes the trigger a no-op rather than a stuck pulse.
  assign trig     = (wr && address == A_TRIG && pulse_len_q != '0) ? wd : '0;
  assign done_clr = (wr && address == A_DONE) ? wd : '0;

  // Next-state for bus registers, prescaler and per-bit pulse engines.
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    data_d      = data_q;
    pulse_len_d = pulse_len_q;
    irq_mask_d  = irq_mask_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    done_set    = '0;

    if (wr) begin
      case (address)
        A_DATA:  data_d      = wd;
        A_SET:   data_d      = data_q | wd;
        A_CLR:   data_d      = data_q & ~wd;
        A_LEN:   pulse_len_d = writedata[LEN_W-1:0];
        A_MASK:  irq_mask_d  = wd;
        default: ;
      endcase
    end

    // Trigger beats a coincident tick, so a retrigger on the last tick
    // reloads instead of expiring.
    for (int i = 0; i < WIDTH; i++) begin
      if (trig[i]) begin
        cnt_d[i]    = pulse_len_q;
        active_d[i] = 1'b1;
      end else if (tick && active_q[i]) begin
        if (cnt_q[i] == LEN_W'(1)) begin
          active_d[i] = 1'b0;
          done_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - LEN_W'(1);
        end
      end
    end

    // Expiry wins over a simultaneous write-1-to-clear.
    done_d = (done_q & ~done_clr) | done_set;

    case (address)
      A_DATA:   readdata_d = 32'(data_q);
      A_LEN:    readdata_d = 32'(pulse_len_q);
      A_ACTIVE: readdata_d = 32'(active_q);
      A_MASK:   readdata_d = 32'(irq_mask_q);
      A_DONE:   readdata_d = 32'(done_q);
      default:  readdata_d = '0;
    endcase
  end

  // State registers; reset clears everything, including mid-pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= '0;
      pulse_len_q <= '0;
      irq_mask_q  <= '0;
      active_q    <= '0;
      done_q      <= '0;
      presc_q     <= '0;
      cnt_q       <= '{default: '0};
      readdata_q  <= '0;
    end else begin
      data_q      <= data_d;
      pulse_len_q <= pulse_len_d;
      irq_mask_q  <= irq_mask_d;
      active_q    <= active_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(done_q & irq_mask_q);
  assign out_port = data_q | active_q;

endmodule
